ca_distributor_mrank: RTL

// Parametrised successor of the 2-rank CA distributor. Fans one registered CA stream out to NUM_RANKS rank ports.

---
 rtl/ca_distributor_mrank_if.sv | 31 +++
 rtl/ca_distributor_mrank.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ca_distributor_mrank_if.sv
// CA fan-out bundle: host CA slot handshake, drain/apply config port and per-rank outputs.
// The distributor uses the slave view; whatever drives the host side uses the master view.
interface ca_distributor_mrank_if #(
    parameter int CA_WIDTH  = 7,
    parameter int NUM_RANKS = 4,
    parameter int MAX_DLY   = 3
);
    localparam int DW = $clog2(MAX_DLY + 1);

    logic [CA_WIDTH-1:0]           ca_in;
    logic                          ca_valid_in;
    logic                          ca_ready;
    logic                          cfg_update;
    logic [NUM_RANKS-1:0]          cfg_rank_en;
    logic [NUM_RANKS*DW-1:0]       cfg_rank_dly;
    logic                          cfg_busy;
    logic                          cfg_err;
    logic [NUM_RANKS*CA_WIDTH-1:0] ca_out;
    logic [NUM_RANKS-1:0]          ca_valid_out;
    logic [NUM_RANKS-1:0]          ca_par_out;

    modport master (
        output ca_in, ca_valid_in, cfg_update, cfg_rank_en, cfg_rank_dly,
        input  ca_ready, cfg_busy, cfg_err, ca_out, ca_valid_out, ca_par_out
    );

    modport slave (
        input  ca_in, ca_valid_in, cfg_update, cfg_rank_en, cfg_rank_dly,
        output ca_ready, cfg_busy, cfg_err, ca_out, ca_valid_out, ca_par_out
    );
endinterface

// File: rtl/ca_distributor_mrank.sv
// Fans one registered CA stream out to NUM_RANKS ports, each with its own deskew tap and
// even parity; enable/delay changes wait until the pipeline has drained.
module ca_distributor_mrank #(
    parameter int CA_WIDTH  = 7,
    parameter int NUM_RANKS = 4,
    parameter int MAX_DLY   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ca_distributor_mrank_if.slave  bus
);
    localparam int DW = $clog2(MAX_DLY + 1);

    typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;

    state_t                  state_reg;
    logic                    ca_ready_reg;
    logic                    cfg_busy_reg;
    logic                    cfg_err_reg;
    logic [NUM_RANKS-1:0]    en_reg;
    logic [NUM_RANKS*DW-1:0] dly_reg;
    logic [NUM_RANKS-1:0]    shadow_en_reg;
    logic [NUM_RANKS*DW-1:0] shadow_dly_reg;
    logic [CA_WIDTH-1:0]     s0_data_reg;
    logic                    s0_valid_reg;
    logic [NUM_RANKS-1:0]    line_busy;
    logic                    shadow_ok;
    logic                    accept;

    assign accept          = bus.ca_valid_in && ca_ready_reg;
    assign bus.ca_ready    = ca_ready_reg;
    assign bus.cfg_busy    = cfg_busy_reg;
    assign bus.cfg_err     = cfg_err_reg;

    always_comb begin
        shadow_ok = |shadow_en_reg;
        for (int r = 0; r < NUM_RANKS; r++) begin
            if ({1'b0, shadow_dly_reg[r*DW +: DW]} > (DW+1)'(MAX_DLY)) begin
                shadow_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RUN;
            ca_ready_reg   <= 1'b1;
            cfg_busy_reg   <= 1'b0;
            cfg_err_reg    <= 1'b0;
            en_reg         <= '1;
            dly_reg        <= '0;
            shadow_en_reg  <= '0;
            shadow_dly_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (bus.cfg_update) begin
                        shadow_en_reg  <= bus.cfg_rank_en;
                        shadow_dly_reg <= bus.cfg_rank_dly;
                        state_reg      <= DRAIN;
                        ca_ready_reg   <= 1'b0;
                        cfg_busy_reg   <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Latest strobe wins until the pipeline is empty.
                    if (bus.cfg_update) begin
                        shadow_en_reg  <= bus.cfg_rank_en;
                        shadow_dly_reg <= bus.cfg_rank_dly;
                    end
                    if (!s0_valid_reg && (line_busy == '0)) begin
                        state_reg <= APPLY;
                    end
                end
                APPLY: begin
                    if (shadow_ok) begin
                        en_reg  <= shadow_en_reg;
                        dly_reg <= shadow_dly_reg;
                    end else begin
                        cfg_err_reg <= 1'b1;
                    end
                    state_reg    <= RUN;
                    ca_ready_reg <= 1'b1;
                    cfg_busy_reg <= 1'b0;
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_reg <= 1'b0;
            s0_data_reg  <= '0;
        end else begin
            s0_valid_reg <= accept;
            if (accept) begin
                s0_data_reg <= bus.ca_in;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
            logic [CA_WIDTH-1:0] line_data_reg [1:MAX_DLY];
            logic [MAX_DLY:1]    line_valid_reg;
            logic [DW-1:0]       tap_sel;
            logic [CA_WIDTH-1:0] tap_data;
            logic                tap_valid;
            logic                take;
            logic [CA_WIDTH-1:0] out_data_reg;
            logic                out_valid_reg;
            logic                out_par_reg;

            assign tap_sel = dly_reg[gi*DW +: DW];

            // Tap 0 is stage 0 itself; tap k is k cycles further down the line.
            always_comb begin
                tap_data  = s0_data_reg;
                tap_valid = s0_valid_reg;
                for (int k = 1; k <= MAX_DLY; k++) begin
                    if (tap_sel == DW'(k)) begin
                        tap_data  = line_data_reg[k];
                        tap_valid = line_valid_reg[k];
                    end
                end
            end

            assign take = en_reg[gi] && tap_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    line_valid_reg <= '0;
                    for (int k = 1; k <= MAX_DLY; k++) begin
                        line_data_reg[k] <= '0;
                    end
                    out_data_reg  <= '0;
                    out_valid_reg <= 1'b0;
                    out_par_reg   <= 1'b0;
                end else begin
                    line_valid_reg[1] <= s0_valid_reg && en_reg[gi];
                    if (s0_valid_reg && en_reg[gi]) begin
                        line_data_reg[1] <= s0_data_reg;
                    end
                    for (int k = 2; k <= MAX_DLY; k++) begin
                        line_valid_reg[k] <= line_valid_reg[k-1];
                        line_data_reg[k]  <= line_data_reg[k-1];
                    end
                    out_valid_reg <= take;
                    if (take) begin
                        out_data_reg <= tap_data;
                        out_par_reg  <= ^tap_data;
                    end
                end
            end

            assign line_busy[gi]                            = |line_valid_reg;
            assign bus.ca_out[gi*CA_WIDTH +: CA_WIDTH]     = out_data_reg;
            assign bus.ca_valid_out[gi]                     = out_valid_reg;
            assign bus.ca_par_out[gi]                       = out_par_reg;
        end
    endgenerate
endmodule
